// File: rtl/k2_pkg.sv
// rtl/k2_pkg.sv - shared K2 loader types and constants
package k2_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LEN  = 3'd1,
        DATA = 3'd2,
        CHK  = 3'd3,
        DONE = 3'd4,
        ERR  = 3'd5
    } loader_state_t;

    localparam int K2_DATA_W = 8;

endpackage

// File: rtl/instr_ram.sv
// rtl/instr_ram.sv - K2 instruction RAM, sync write port, async read port
module instr_ram
    import k2_pkg::*;
#(
    parameter int ADDR_W = 4
) (
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [ADDR_W-1:0]    wr_addr,
    input  logic [K2_DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0]    rd_addr,
    output logic [K2_DATA_W-1:0] rd_data
);

    localparam int DEPTH = 2 ** ADDR_W;

    // No reset: a verified program survives a processor-side reset.
    logic [K2_DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/program_loader.sv
// rtl/program_loader.sv - framed host loader for the K2 instruction RAM
module program_loader
    import k2_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = K2_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic [7:0]        cpu_data,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    localparam int         DEPTH   = 2 ** ADDR_W;
    localparam logic [8:0] DEPTH_9 = 9'(DEPTH);

    loader_state_t   state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [7:0]        sum_q, sum_d;
    logic [ADDR_W:0]   words_q, words_d;
    logic              wr_en;
    logic              accept;
    logic [7:0]        sum_next;
    logic [ADDR_W:0]   words_next;

    assign busy     = (state_q == LEN) || (state_q == DATA) || (state_q == CHK);
    assign in_ready = busy;
    assign accept   = in_valid && in_ready;
    assign done     = (state_q == DONE);
    assign error    = (state_q == ERR);
    assign cpu_hold = (state_q != DONE);
    assign words_loaded = words_q;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        len_d      = len_q;
        sum_d      = sum_q;
        words_d    = words_q;
        wr_en      = 1'b0;
        sum_next   = sum_q + in_data;
        words_next = words_q + 1'b1;
        case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_d = LEN;
                    words_d = '0;
                end
            end
            LEN: begin
                if (accept) begin
                    if ((in_data != 8'h00) && ({1'b0, in_data} <= DEPTH_9)) begin
                        len_d   = in_data[ADDR_W:0];
                        addr_d  = '0;
                        sum_d   = 8'h00;
                        state_d = DATA;
                    end else begin
                        state_d = ERR;
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    wr_en   = 1'b1;
                    addr_d  = addr_q + 1'b1;
                    sum_d   = sum_next;
                    words_d = words_next;
                    if (words_next == len_q) begin
                        state_d = CHK;
                    end
                end
            end
            CHK: begin
                if (accept) begin
                    state_d = (sum_next == 8'h00) ? DONE : ERR;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            sum_q   <= 8'h00;
            words_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            sum_q   <= sum_d;
            words_q <= words_d;
        end
    end

    instr_ram #(
        .ADDR_W (ADDR_W)
    ) u_instr_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (addr_q),
        .wr_data (in_data),
        .rd_addr (cpu_addr),
        .rd_data (cpu_data)
    );

endmodule
